// File: rtl/vga_sync_tracker.sv
// Recovers pixel/line position from a VGA Hsync/Vsync pair and reports lock and sync errors.
// Define VGA_SYNC_TRACKER_ERRCNT_EN to build the saturating err_count; otherwise it is tied to 0.
module vga_sync_tracker #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int H_SYNC_START = 655,
    parameter int H_SYNC_END   = 750,
    parameter int V_SYNC_START = 489,
    parameter int V_SYNC_END   = 490,
    parameter int LOCK_LINES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Hsync,
    input  logic        Vsync,
    output logic [10:0] Hpixel,
    output logic [10:0] Vpixel,
    output logic        active,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_start,
    output logic [7:0]  err_count
);

    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [10:0]   H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0]   V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0]   H_FALL_POS = 11'(H_SYNC_START);
    localparam logic [10:0]   H_REALIGN  = 11'(H_SYNC_START + 1);
    localparam logic [10:0]   H_RISE_POS = 11'(H_SYNC_END + 1);
    localparam logic [10:0]   V_FALL_POS = 11'(V_SYNC_START);
    localparam logic [10:0]   V_RISE_POS = 11'(V_SYNC_END + 1);
    localparam logic [GW-1:0] GOOD_MAX   = GW'(LOCK_LINES);

    logic [10:0]   hcnt_q, hcnt_d;
    logic [10:0]   vcnt_q, vcnt_d;
    logic          hs_q, vs_q;
    logic [GW-1:0] good_lines_q, good_lines_d;
    logic          v_ok_q, v_ok_d;
    logic          locked_q, locked_d;

    logic h_fall, h_rise, v_fall, v_rise;
    logic h_good, h_misfall, h_err;
    logic v_good, v_misfall, v_err;
    logic h_wrap, any_err;

    // NOTE: every always_comb output gets a default before any condition, so no latches form.
    always_comb begin
        h_fall    = hs_q & ~Hsync;
        h_rise    = ~hs_q & Hsync;
        v_fall    = vs_q & ~Vsync;
        v_rise    = ~vs_q & Vsync;

        h_good    = h_fall && (hcnt_q == H_FALL_POS);
        h_misfall = h_fall && !h_good;
        // A high hs_q one column after the expected fall means the fall never came.
        h_err     = h_misfall
                  || (h_rise && (hcnt_q != H_RISE_POS))
                  || ((hcnt_q == H_REALIGN) && hs_q);

        v_good    = v_fall && (hcnt_q == '0) && (vcnt_q == V_FALL_POS);
        v_misfall = v_fall && !v_good;
        v_err     = v_misfall
                  || (v_rise && !((hcnt_q == '0) && (vcnt_q == V_RISE_POS)));

        any_err   = h_err || v_err;

        hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 11'd1;
        if (h_misfall) hcnt_d = H_REALIGN;
        h_wrap = (hcnt_q == H_LAST) && !h_misfall;

        vcnt_d = vcnt_q;
        if (h_wrap) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
        if (v_misfall) vcnt_d = V_FALL_POS;

        good_lines_d = good_lines_q;
        if (h_err) good_lines_d = '0;
        else if (h_good && (good_lines_q != GOOD_MAX)) good_lines_d = good_lines_q + 1'b1;

        v_ok_d = v_ok_q;
        if (v_err) v_ok_d = 1'b0;
        else if (v_good) v_ok_d = 1'b1;

        // Built from next-state values so lock drops on the cycle right after an error.
        locked_d = (good_lines_d == GOOD_MAX) && v_ok_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            good_lines_q <= '0;
            v_ok_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            hs_q         <= Hsync;
            vs_q         <= Vsync;
            good_lines_q <= good_lines_d;
            v_ok_q       <= v_ok_d;
            locked_q     <= locked_d;
        end
    end

    // Outputs are masked by rst so they read 0 from the first reset cycle onward.
    assign Hpixel      = rst ? '0 : hcnt_q;
    assign Vpixel      = rst ? '0 : vcnt_q;
    assign locked      = locked_q && !rst;
    assign sync_err    = any_err && !rst;
    assign active      = locked && (hcnt_q < 11'(H_ACTIVE)) && (vcnt_q < 11'(V_ACTIVE));
    assign frame_start = locked && (hcnt_q == '0) && (vcnt_q == '0);

`ifdef VGA_SYNC_TRACKER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = rst ? '0 : err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Directed bench for vga_sync_tracker using a shrunken 40x20 raster driven by an in-bench generator.
module tb_vga_sync_tracker;

    localparam int HT = 40, HA = 32, HSS = 34, HSE = 37;
    localparam int VT = 20, VA = 15, VSS = 16, VSE = 17;
`ifdef VGA_SYNC_TRACKER_ERRCNT_EN
    localparam logic [7:0] EXP_SAT = 8'd255;
`else
    localparam logic [7:0] EXP_SAT = 8'd0;
`endif

    logic        clk, rst;
    logic        Hsync, Vsync;
    logic [10:0] Hpixel, Vpixel;
    logic        active, locked, sync_err, frame_start;
    logic [7:0]  err_count;

    logic        gen_rst;
    logic [10:0] gen_h, gen_v;
    logic        flood;
    int          h_skip_line, v_glitch_line;

    int checks = 0;
    int errors = 0;
    int err_since_rst = 0;
    int fs_count = 0;
    int fs_mark;

    vga_sync_tracker #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .V_ACTIVE(VA), .V_TOTAL(VT),
        .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_SYNC_START(VSS), .V_SYNC_END(VSE), .LOCK_LINES(4)
    ) dut (
        .clk(clk), .rst(rst), .Hsync(Hsync), .Vsync(Vsync),
        .Hpixel(Hpixel), .Vpixel(Vpixel), .active(active), .locked(locked),
        .sync_err(sync_err), .frame_start(frame_start), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timing generator on the same clock.
    always @(posedge clk) begin
        if (gen_rst) begin
            gen_h <= '0;
            gen_v <= '0;
        end else if (gen_h == 11'(HT - 1)) begin
            gen_h <= '0;
            gen_v <= (gen_v == 11'(VT - 1)) ? 11'd0 : gen_v + 11'd1;
        end else begin
            gen_h <= gen_h + 11'd1;
        end
    end

    assign Hsync = flood ? gen_h[0]
                 : (int'(gen_v) == h_skip_line) ? 1'b1
                 : !(gen_h >= 11'(HSS) && gen_h <= 11'(HSE));
    assign Vsync = (int'(gen_v) == v_glitch_line) ? 1'b0
                 : !(gen_v >= 11'(VSS) && gen_v <= 11'(VSE));

    always @(negedge clk) begin
        if (rst) err_since_rst = 0;
        else if (sync_err) err_since_rst++;
        if (frame_start) fs_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gen(input int h, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(gen_h) == h && int'(gen_v) == v) && n < 2000);
        if (!(int'(gen_h) == h && int'(gen_v) == v)) begin
            checks++;
            errors++;
            $error("FAIL wait_gen timeout: observed %0d,%0d expected %0d,%0d", gen_h, gen_v, h, v);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hpix"}, 64'(Hpixel), 64'd0);
        check({tag, "_vpix"}, 64'(Vpixel), 64'd0);
        check({tag, "_flags"}, 64'({active, locked, sync_err, frame_start}), 64'd0);
        check({tag, "_errcnt"}, 64'(err_count), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        gen_rst = 1'b1;
        flood = 1'b0;
        h_skip_line = -1;
        v_glitch_line = -1;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Common release: lock one cycle after the V fall at line VSS.
        rst = 1'b0;
        gen_rst = 1'b0;
        wait_gen(HT - 1, VSS - 1);
        check("prelock", 64'(locked), 64'd0);
        wait_gen(0, VSS);
        check("vfall_locked", 64'({locked, sync_err}), 64'b00);
        @(negedge clk);
        check("lock_cycle", 64'(locked), 64'd1);
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge clk);
            check("track", {gen_h, gen_v, gen_h < 11'(HA) && gen_v < 11'(VA), 1'b1, 1'b0,
                            gen_h == 11'd0 && gen_v == 11'd0, 8'd0},
                  {Hpixel, Vpixel, active, locked, sync_err, frame_start, err_count});
        end

        // Missing Hsync pulse on line 5.
        h_skip_line = 5;
        wait_gen(HSS + 1, 5);
        check("hmiss_err", 64'({sync_err, locked}), 64'b11);
        @(negedge clk);
        check("hmiss_drop", 64'(locked), 64'd0);
        wait_gen(0, 6);
        h_skip_line = -1;
        wait_gen(HSS, 9);
        check("hrelock_pre", 64'(locked), 64'd0);
        @(negedge clk);
        check("hrelock", 64'(locked), 64'd1);

        // Spurious Vsync fall on line 5.
        v_glitch_line = 5;
        wait_gen(0, 5);
        check("vglitch_err", 64'({sync_err, locked}), 64'b11);
        @(negedge clk);
        check("vglitch_jump", 64'({Hpixel, Vpixel, locked}), {11'd1, 11'(VSS), 1'b0});
        wait_gen(5, 6);
        v_glitch_line = -1;
        wait_gen(0, VSS);
        check("vrealign_err", 64'({Vpixel, sync_err}), {11'd7, 1'b1});
        @(negedge clk);
        check("vrealign_pos", 64'({Vpixel, locked}), {11'(VSS), 1'b0});
        wait_gen(0, 0);
        check("vunlocked_fs", 64'({frame_start, locked}), 64'b00);
        wait_gen(0, VSS);
        check("vgood_fall", 64'({sync_err, Vpixel}), {1'b0, 11'(VSS)});
        @(negedge clk);
        check("vrelock", 64'(locked), 64'd1);

        // One-cycle reset mid-frame while locked.
        wait_gen(10, 3);
        check("pre_rst_lock", 64'(locked), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mask", 64'({Hpixel, locked}), 64'd0);
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        fs_mark = fs_count;
        wait_gen(HSS, 3);
        check("rst_hrealign", 64'({Hpixel, sync_err}), {11'd23, 1'b1});
        wait_gen(0, VSS);
        check("rst_vrealign", 64'({Vpixel, sync_err}), {11'd13, 1'b1});
        wait_gen(0, 0);
        check("rst_no_fs", 64'(frame_start), 64'd0);
        wait_gen(1, VSS);
        check("rst_relock", 64'(locked), 64'd1);
        check("rst_fs_count", 64'(fs_count), 64'(fs_mark));
        wait_gen(0, 0);
        check("rst_fs", 64'(frame_start), 64'd1);

        // Tracker released 100 cycles after the generator.
        rst = 1'b1;
        gen_rst = 1'b1;
        repeat (2) @(negedge clk);
        gen_rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b0;
        wait_gen(HSS, 2);
        check("late_hfall", 64'({Hpixel, sync_err}), {11'd14, 1'b1});
        @(negedge clk);
        check("late_hrealign", 64'(Hpixel), 64'(HSS + 1));
        wait_gen(0, VSS);
        check("late_vfall", 64'({Vpixel, sync_err}), {11'd14, 1'b1});
        @(negedge clk);
        check("late_vpos", 64'({Vpixel, locked}), {11'(VSS), 1'b0});
        wait_gen(0, VSS);
        check("late_prelock", 64'({locked, sync_err}), 64'b00);
        @(negedge clk);
        check("late_lock", 64'(locked), 64'd1);

        // Error flood: toggling Hsync every cycle.
        flood = 1'b1;
        repeat (700) @(negedge clk);
        flood = 1'b0;
        repeat (2) @(negedge clk);
        check("flood_errs", 64'(err_since_rst >= 300), 64'd1);
        check("err_count_sat", 64'(err_count), 64'(EXP_SAT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
